// File: rtl/mmio_fifo_port.sv
// -----------------------------------------------------------------------------
// mmio_fifo_port
//   Peripheral end of one MMIO controller port. CPU writes arrive as an
//   even/odd word pair plus an inform_write pulse; the odd word carries an
//   opcode (PUSH into the TX FIFO, clear TX, clear RX, NOP). CPU reads arrive
//   as an inform_read pulse that pops the RX FIFO. The port presents the RX
//   head on its even input word and a status word on its odd input word.
//   The TX FIFO is drained by an external valid/ready consumer; the RX FIFO
//   is filled by an external valid/ready producer.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   port_wr_data   [15:0]  TX payload from the controller
//   port_wr_ctrl   [15:0]  bits[1:0] opcode, upper bits ignored
//   port_inform_write      one-cycle pulse: CPU wrote this port
//   port_inform_read       one-cycle pulse: CPU read this port
//   port_rd_data   [15:0]  RX FIFO head (0 when empty)
//   port_rd_status [15:0]  {tx_full, tx_empty, rx_full, rx_empty,
//                           tx_overflow, rx_underflow, tx_count, rx_count}
//   tx_data/tx_valid/tx_ready   TX FIFO head to the external consumer
//   rx_data/rx_valid/rx_ready   external producer into the RX FIFO
// -----------------------------------------------------------------------------
module mmio_fifo_port #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] port_wr_data,
   input  logic [15:0] port_wr_ctrl,
   input  logic        port_inform_write,
   input  logic        port_inform_read,
   output logic [15:0] port_rd_data,
   output logic [15:0] port_rd_status,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [15:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int         PW      = $clog2(DEPTH);
   localparam logic [4:0] W_DEPTH = 5'(DEPTH);

   typedef enum logic [1:0] {
      OP_PUSH   = 2'b00,
      OP_CLR_TX = 2'b01,
      OP_CLR_RX = 2'b10,
      OP_NOP    = 2'b11
   } op_e;

   // ---------------------------------------------------------------- TX FIFO
   logic [15:0]   r_tx_mem [DEPTH];
   logic [PW-1:0] r_tx_rd_ptr;
   logic [PW-1:0] r_tx_wr_ptr;
   logic [4:0]    r_tx_count;
   logic          r_tx_overflow;

   // ---------------------------------------------------------------- RX FIFO
   logic [15:0]   r_rx_mem [DEPTH];
   logic [PW-1:0] r_rx_rd_ptr;
   logic [PW-1:0] r_rx_wr_ptr;
   logic [4:0]    r_rx_count;
   logic          r_rx_underflow;

   op_e  w_op;
   logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic w_push, w_clr_tx, w_clr_rx;
   logic w_tx_wr_en, w_tx_rd_en, w_rx_wr_en, w_rx_rd_en;

   assign w_op       = op_e'(port_wr_ctrl[1:0]);

   assign w_tx_empty = (r_tx_count == 5'd0);
   assign w_tx_full  = (r_tx_count == W_DEPTH);
   assign w_rx_empty = (r_rx_count == 5'd0);
   assign w_rx_full  = (r_rx_count == W_DEPTH);

   assign w_push     = port_inform_write && (w_op == OP_PUSH);
   assign w_clr_tx   = port_inform_write && (w_op == OP_CLR_TX);
   assign w_clr_rx   = port_inform_write && (w_op == OP_CLR_RX);

   // Fullness is judged on pre-edge state, so a same-edge drain never makes
   // room for a push that arrives while the FIFO is full.
   assign w_tx_wr_en = w_push && !w_tx_full;
   assign w_tx_rd_en = tx_ready && !w_tx_empty;
   assign w_rx_wr_en = rx_valid && rx_ready;
   assign w_rx_rd_en = port_inform_read && !w_rx_empty;

   // NOTE: storage arrays carry no reset; the pointers and counts define
   // which entries are valid, so resetting the array would only add muxes.
   always_ff @(posedge clk) begin
      if (w_tx_wr_en) r_tx_mem[r_tx_wr_ptr] <= port_wr_data;
      if (w_rx_wr_en) r_rx_mem[r_rx_wr_ptr] <= rx_data;
   end

   // NOTE: all state registers use non-blocking assignments so every branch
   // sees the pre-edge values, matching the pre-edge full/empty decisions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_rd_ptr   <= '0;
         r_tx_wr_ptr   <= '0;
         r_tx_count    <= '0;
         r_tx_overflow <= 1'b0;
      end else if (w_clr_tx) begin
         // Clear takes priority over a concurrent drain.
         r_tx_rd_ptr   <= '0;
         r_tx_wr_ptr   <= '0;
         r_tx_count    <= '0;
         r_tx_overflow <= 1'b0;
      end else begin
         if (w_tx_wr_en)            r_tx_wr_ptr   <= r_tx_wr_ptr + PW'(1);
         if (w_tx_rd_en)            r_tx_rd_ptr   <= r_tx_rd_ptr + PW'(1);
         if (w_push && w_tx_full)   r_tx_overflow <= 1'b1;
         case ({w_tx_wr_en, w_tx_rd_en})
            2'b10:   r_tx_count <= r_tx_count + 5'd1;
            2'b01:   r_tx_count <= r_tx_count - 5'd1;
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_rd_ptr    <= '0;
         r_rx_wr_ptr    <= '0;
         r_rx_count     <= '0;
         r_rx_underflow <= 1'b0;
      end else if (w_clr_rx) begin
         // Clear beats a concurrent fill/pop and suppresses underflow.
         r_rx_rd_ptr    <= '0;
         r_rx_wr_ptr    <= '0;
         r_rx_count     <= '0;
         r_rx_underflow <= 1'b0;
      end else begin
         if (w_rx_wr_en)                     r_rx_wr_ptr    <= r_rx_wr_ptr + PW'(1);
         if (w_rx_rd_en)                     r_rx_rd_ptr    <= r_rx_rd_ptr + PW'(1);
         if (port_inform_read && w_rx_empty) r_rx_underflow <= 1'b1;
         case ({w_rx_wr_en, w_rx_rd_en})
            2'b10:   r_rx_count <= r_rx_count + 5'd1;
            2'b01:   r_rx_count <= r_rx_count - 5'd1;
            default: r_rx_count <= r_rx_count;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign tx_valid       = !w_tx_empty;
   assign tx_data        = w_tx_empty ? 16'h0000 : r_tx_mem[r_tx_rd_ptr];
   assign rx_ready       = !rst && !w_rx_full;
   assign port_rd_data   = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rd_ptr];
   assign port_rd_status = {w_tx_full, w_tx_empty, w_rx_full, w_rx_empty,
                            r_tx_overflow, r_rx_underflow,
                            r_tx_count, r_rx_count};

endmodule

// File: tb/tb_mmio_fifo_port.sv
// -----------------------------------------------------------------------------
// tb_mmio_fifo_port
//   Directed scenarios followed by randomized traffic. A queue-based model
//   tracks both FIFOs and the sticky flags; a negedge process compares every
//   DUT output against it each cycle, and directed steps pin the model with
//   hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_mmio_fifo_port;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] port_wr_data = '0;
   logic [15:0] port_wr_ctrl = '0;
   logic        port_inform_write = 1'b0;
   logic        port_inform_read = 1'b0;
   logic [15:0] port_rd_data;
   logic [15:0] port_rd_status;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [15:0] rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;

   mmio_fifo_port #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .port_wr_data      (port_wr_data),
      .port_wr_ctrl      (port_wr_ctrl),
      .port_inform_write (port_inform_write),
      .port_inform_read  (port_inform_read),
      .port_rd_data      (port_rd_data),
      .port_rd_status    (port_rd_status),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_ready          (rx_ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   logic [15:0] tx_q[$];
   logic [15:0] rx_q[$];
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;

   task automatic model_step();
      bit          tx_was_full, tx_drain, rx_was_full, rx_was_empty;
      logic [1:0]  op;
      op = port_wr_ctrl[1:0];
      if (rst) begin
         tx_q.delete(); rx_q.delete();
         m_ovf = 1'b0; m_unf = 1'b0;
         return;
      end
      tx_was_full  = (tx_q.size() == DEPTH);
      tx_drain     = (tx_q.size() > 0) && tx_ready;
      rx_was_full  = (rx_q.size() == DEPTH);
      rx_was_empty = (rx_q.size() == 0);
      if (port_inform_write && op == 2'b01) begin
         tx_q.delete(); m_ovf = 1'b0;
      end else begin
         if (tx_drain) void'(tx_q.pop_front());
         if (port_inform_write && op == 2'b00) begin
            if (tx_was_full) m_ovf = 1'b1;
            else             tx_q.push_back(port_wr_data);
         end
      end
      if (port_inform_write && op == 2'b10) begin
         rx_q.delete(); m_unf = 1'b0;
      end else begin
         if (port_inform_read) begin
            if (rx_was_empty) m_unf = 1'b1;
            else              void'(rx_q.pop_front());
         end
         if (rx_valid && !rx_was_full) rx_q.push_back(rx_data);
      end
   endtask

   function automatic logic [15:0] exp_status();
      return {tx_q.size() == DEPTH, tx_q.size() == 0,
              rx_q.size() == DEPTH, rx_q.size() == 0,
              m_ovf, m_unf, 5'(tx_q.size()), 5'(rx_q.size())};
   endfunction

   always @(posedge clk) model_step();

   // ------------------------------------------------------------ compare
   always @(negedge clk) begin
      if (chk_en) begin
         check("tx_valid", 16'(tx_valid), 16'(tx_q.size() > 0));
         check("tx_data", tx_data, (tx_q.size() > 0) ? tx_q[0] : 16'h0000);
         check("rd_data", port_rd_data, (rx_q.size() > 0) ? rx_q[0] : 16'h0000);
         check("status", port_rd_status, exp_status());
         check("rx_ready", 16'(rx_ready), 16'(!rst && rx_q.size() < DEPTH));
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic peek();
      @(negedge clk); #1;
   endtask

   task automatic wr(input logic [1:0] op, input logic [15:0] d);
      port_wr_ctrl      = {14'h0, op};
      port_wr_data      = d;
      port_inform_write = 1'b1;
      cyc();
      port_inform_write = 1'b0;
   endtask

   task automatic rd();
      port_inform_read = 1'b1;
      cyc();
      port_inform_read = 1'b0;
   endtask

   initial begin
      // Reset, then idle
      cyc(); chk_en = 1'b1;
      cyc();
      rst = 1'b0;
      peek();
      check("rst_status", port_rd_status, 16'h5000);
      check("rst_tx_valid", 16'(tx_valid), 16'h0);
      check("rst_rx_ready", 16'(rx_ready), 16'h1);
      check("rst_rd_data", port_rd_data, 16'h0000);

      // Three pushes with the consumer stalled, then drain in order
      tx_ready = 1'b0;
      wr(2'b00, 16'h1111); wr(2'b00, 16'h2222); wr(2'b00, 16'h3333);
      peek();
      check("tx3_status", port_rd_status, 16'h1060);
      tx_ready = 1'b1;
      check("tx3_head0", tx_data, 16'h1111);
      peek(); check("tx3_head1", tx_data, 16'h2222);
      peek(); check("tx3_head2", tx_data, 16'h3333);
      peek(); check("tx3_empty", 16'(tx_valid), 16'h0);
      check("tx3_status_end", port_rd_status, 16'h5000);

      // Overflow: nine pushes into eight entries
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(2'b00, 16'hA000 + 16'(i));
      peek();
      check("ovf_status", port_rd_status, 16'h9900);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("ovf_drain", tx_data, 16'hA000 + 16'(i));
         peek();
      end
      check("ovf_sticky", port_rd_status, 16'h5800);
      tx_ready = 1'b0;
      wr(2'b01, 16'h0000);
      peek();
      check("clr_tx_status", port_rd_status, 16'h5000);

      // RX fill, show-ahead reads, underflow
      rx_data = 16'hBEEF; rx_valid = 1'b1; cyc();
      rx_data = 16'hCAFE; cyc();
      rx_valid = 1'b0;
      peek();
      check("rx2_head", port_rd_data, 16'hBEEF);
      check("rx2_status", port_rd_status, 16'h4002);
      rd(); peek();
      check("rx2_next", port_rd_data, 16'hCAFE);
      rd(); rd(); peek();
      check("unf_status", port_rd_status, 16'h5400);
      wr(2'b10, 16'h0000);
      peek();
      check("clr_rx_status", port_rd_status, 16'h5000);

      // RX full: pop plus refused fill, then fill plus pop
      for (int i = 0; i < 8; i++) begin
         rx_data = 16'h00C0 + 16'(i); rx_valid = 1'b1; cyc();
      end
      rx_valid = 1'b0;
      peek();
      check("rxf_ready", 16'(rx_ready), 16'h0);
      check("rxf_status", port_rd_status, 16'h6008);
      rx_data = 16'hDEAD; rx_valid = 1'b1; port_inform_read = 1'b1; cyc();
      rx_valid = 1'b0; port_inform_read = 1'b0;
      peek();
      check("rxf_ready2", 16'(rx_ready), 16'h1);
      check("rxf_status2", port_rd_status, 16'h4007);
      check("rxf_head2", port_rd_data, 16'h00C1);
      rx_data = 16'hBEAD; rx_valid = 1'b1; port_inform_read = 1'b1; cyc();
      rx_valid = 1'b0; port_inform_read = 1'b0;
      peek();
      check("rxfp_status", port_rd_status, 16'h4007);
      check("rxfp_head", port_rd_data, 16'h00C2);
      wr(2'b10, 16'h0000);

      // Push, then reset with the consumer ready
      tx_ready = 1'b0;
      wr(2'b00, 16'h5555);
      rst = 1'b1; tx_ready = 1'b1;
      cyc();
      rst = 1'b0;
      peek();
      check("mid_rst_status", port_rd_status, 16'h5000);
      check("mid_rst_tx_valid", 16'(tx_valid), 16'h0);

      // Sixteen back-to-back push/drain pairs wrap the pointers twice
      for (int i = 0; i < 16; i++) wr(2'b00, 16'($urandom));
      peek(); peek();
      check("wrap_status", port_rd_status, 16'h5000);

      // Randomized traffic, two phases with different consumer/reader pressure
      for (int i = 0; i < 2000; i++) begin
         int r;
         bit slow;
         slow              = (i < 1000);
         rst               = ($urandom_range(0, 149) == 0);
         port_inform_write = ($urandom_range(0, 2) == 0);
         r                 = $urandom_range(0, 8);
         port_wr_ctrl      = {14'($urandom),
                              (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11};
         port_wr_data      = 16'($urandom);
         port_inform_read  = slow ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
         rx_valid          = ($urandom_range(0, 1) == 0);
         rx_data           = 16'($urandom);
         tx_ready          = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cyc();
      end
      rst = 1'b0; port_inform_write = 1'b0; port_inform_read = 1'b0;
      rx_valid = 1'b0; tx_ready = 1'b0;
      peek(); peek();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
